// File: rtl/input_conditioner.sv
// input_conditioner
//
// Conditions raw board pins (push-buttons, slide switches) for the SoC.
// Each channel is synchronised into the clk_i domain through a
// SYNC_STAGES-deep flop chain, then debounced: a synchronised value that
// differs from the accepted level must persist for the debounce threshold
// of consecutive cycles before it becomes the new level. An accepted change
// emits a registered one-cycle rise or fall pulse, coincident with the first
// cycle of the new level.
//
// Parameters:
//   WIDTH           number of independent channels
//   SYNC_STAGES     synchroniser depth (>= 2)
//   DEBOUNCE_CYCLES consecutive cycles a change must hold (>= 1)
//
// Ports:
//   clk_i       system clock
//   arst_i      asynchronous active-high reset
//   raw_i       unsynchronised pin levels
//   level_o     debounced level per channel
//   rise_o      one-cycle pulse on an accepted 0->1 transition
//   fall_o      one-cycle pulse on an accepted 1->0 transition
//   any_rise_o  OR of rise_o, registered so it lines up with rise_o
//
// Build option:
//   INPUT_CONDITIONER_SIM_FAST_EN  when defined, the threshold is
//   min(DEBOUNCE_CYCLES, 4) so full-SoC simulations do not wait for
//   hundreds of thousands of cycles. Ports and behaviour are otherwise
//   unchanged.

module input_conditioner #(
  parameter int WIDTH           = 17,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             any_rise_o
);

  // Counter is sized for the full DEBOUNCE_CYCLES even in fast mode, so the
  // register layout does not depend on the build option.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

`ifdef INPUT_CONDITIONER_SIM_FAST_EN
  localparam int THRESH = (DEBOUNCE_CYCLES < 4) ? DEBOUNCE_CYCLES : 4;
`else
  localparam int THRESH = DEBOUNCE_CYCLES;
`endif

  // Counter value on the edge that completes THRESH consecutive mismatches.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(THRESH - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] rise_q,  rise_d;
  logic [WIDTH-1:0] fall_q,  fall_d;
  logic             any_rise_q, any_rise_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Synchroniser shift: stage 0 samples the pin, later stages follow.
  always_comb begin
    sync_d[0] = raw_i;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Debounce and pulse generation. A mismatch that returns to the stable
  // level before the threshold simply clears the counter.
  always_comb begin
    level_d = level_q;
    rise_d  = {WIDTH{1'b0}};
    fall_d  = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (s[i] == level_q[i]) begin
        cnt_d[i] = {CNT_W{1'b0}};
      end else if (cnt_q[i] == CNT_LAST) begin
        level_d[i] = s[i];
        cnt_d[i]   = {CNT_W{1'b0}};
        rise_d[i]  = s[i];
        fall_d[i]  = ~s[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    any_rise_d = |rise_d;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= {WIDTH{1'b0}};
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= {CNT_W{1'b0}};
      end
      level_q    <= {WIDTH{1'b0}};
      rise_q     <= {WIDTH{1'b0}};
      fall_q     <= {WIDTH{1'b0}};
      any_rise_q <= 1'b0;
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      level_q    <= level_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      any_rise_q <= any_rise_d;
    end
  end

  assign level_o    = level_q;
  assign rise_o     = rise_q;
  assign fall_o     = fall_q;
  assign any_rise_o = any_rise_q;

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner
//
// Self-checking bench for input_conditioner with WIDTH=4, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=8. A reference model tracks, per channel, how many
// consecutive edges the delayed pin value has disagreed with the accepted
// level; it accepts on the threshold-th disagreement. Scenario tasks also
// check the literal edge numbers expected for each scenario.

module tb_input_conditioner;

  localparam int W    = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 8;
`ifdef INPUT_CONDITIONER_SIM_FAST_EN
  localparam int THR  = (DEB < 4) ? DEB : 4;
`else
  localparam int THR  = DEB;
`endif
  localparam int LAT  = SYNC + THR;

  logic         clk_i = 1'b0;
  logic         arst_i;
  logic [W-1:0] raw_i;
  logic [W-1:0] level_o, rise_o, fall_o;
  logic         any_rise_o;

  input_conditioner #(
    .WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk_i(clk_i), .arst_i(arst_i), .raw_i(raw_i),
    .level_o(level_o), .rise_o(rise_o), .fall_o(fall_o),
    .any_rise_o(any_rise_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [W-1:0] hist[$];
  int           run [W];
  logic [W-1:0] m_level, m_rise, m_fall;
  logic         m_any;

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < SYNC; k++) hist.push_back(4'h0);
    for (int c = 0; c < W; c++) run[c] = 0;
    m_level = 4'h0; m_rise = 4'h0; m_fall = 4'h0; m_any = 1'b0;
  endtask

  // One clock edge: the pin value seen at an edge reaches the debouncer
  // SYNC edges later. Returns 1 ns after the edge.
  task automatic step();
    logic [W-1:0] smp;
    logic [W-1:0] s;
    smp = raw_i;
    @(posedge clk_i);
    if (arst_i) begin
      model_reset();
    end else begin
      hist.push_back(smp);
      s = hist.pop_front();
      m_rise = 4'h0; m_fall = 4'h0;
      for (int c = 0; c < W; c++) begin
        if (s[c] != m_level[c]) begin
          run[c]++;
          if (run[c] == THR) begin
            m_level[c] = s[c];
            run[c] = 0;
            if (s[c]) m_rise[c] = 1'b1;
            else      m_fall[c] = 1'b1;
          end
        end else begin
          run[c] = 0;
        end
      end
      m_any = |m_rise;
    end
    #1;
  endtask

  task automatic test_reset();
    arst_i = 1'b1; raw_i = 4'h0; model_reset();
    repeat (3) step();
    checks++;
    if ({level_o, rise_o, fall_o, any_rise_o} !== 13'h0) begin
      errors++; $display("FAIL reset_hold got %h exp 0", {level_o, rise_o, fall_o, any_rise_o});
    end
    #2 arst_i = 1'b0;
    raw_i = 4'hF;
    for (int i = 1; i <= LAT + 2; i++) begin
      step();
      checks++;
      if (rise_o !== ((i == LAT) ? 4'hF : 4'h0) || level_o !== ((i >= LAT) ? 4'hF : 4'h0)) begin
        errors++; $display("FAIL reset_first_rise edge %0d got lvl %h rise %h", i, level_o, rise_o);
      end
    end
    // Go mid-count towards a release, then reset asynchronously.
    raw_i = 4'h0;
    repeat (5) step();
    #2 arst_i = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({level_o, rise_o, fall_o, any_rise_o} !== 13'h0) begin
      errors++; $display("FAIL reset_async got %h exp 0", {level_o, rise_o, fall_o, any_rise_o});
    end
    raw_i = 4'hF;
    repeat (3) step();
    #2 arst_i = 1'b0;
    for (int i = 1; i <= LAT + 2; i++) begin
      step();
      checks++;
      if (rise_o !== ((i == LAT) ? 4'hF : 4'h0) || any_rise_o !== (i == LAT)
          || {level_o, rise_o, fall_o, any_rise_o} !== {m_level, m_rise, m_fall, m_any}) begin
        errors++; $display("FAIL reset_release edge %0d got rise %h any %b lvl %h", i, rise_o, any_rise_o, level_o);
      end
    end
  endtask

  task automatic test_clean_press();
    raw_i = 4'h0;
    repeat (LAT + 4) step();
    checks++;
    if ({level_o, rise_o, fall_o, any_rise_o} !== {m_level, m_rise, m_fall, m_any} || level_o !== 4'h0) begin
      errors++; $display("FAIL press_idle got lvl %h exp 0", level_o);
    end
    raw_i = 4'b0001;
    for (int i = 1; i <= LAT + 2; i++) begin
      step();
      checks++;
      if (level_o[0] !== (i >= LAT) || rise_o[0] !== (i == LAT) || fall_o !== 4'h0
          || {level_o, rise_o, fall_o, any_rise_o} !== {m_level, m_rise, m_fall, m_any}) begin
        errors++; $display("FAIL press edge %0d got lvl %h rise %h fall %h", i, level_o, rise_o, fall_o);
      end
    end
    raw_i = 4'b0000;
    for (int i = 1; i <= LAT + 2; i++) begin
      step();
      checks++;
      if (level_o[0] !== (i < LAT) || fall_o[0] !== (i == LAT) || rise_o !== 4'h0
          || {level_o, rise_o, fall_o, any_rise_o} !== {m_level, m_rise, m_fall, m_any}) begin
        errors++; $display("FAIL release edge %0d got lvl %h rise %h fall %h", i, level_o, rise_o, fall_o);
      end
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 7 + 1 + 7 + LAT + 4; i++) begin
      raw_i = (i < 7 || (i >= 8 && i < 15)) ? 4'b0010 : 4'b0000;
      step();
      checks++;
      if (level_o[1] !== 1'b0 || rise_o !== 4'h0 || fall_o !== 4'h0 || any_rise_o !== 1'b0
          || {level_o, rise_o, fall_o, any_rise_o} !== {m_level, m_rise, m_fall, m_any}) begin
        errors++; $display("FAIL bounce step %0d got lvl %h rise %h fall %h", i, level_o, rise_o, fall_o);
      end
    end
  endtask

  task automatic test_simultaneous();
    int n_any;
    int at;
    n_any = 0; at = -1;
    raw_i = 4'b1100;
    for (int i = 1; i <= LAT + 4; i++) begin
      step();
      if (any_rise_o === 1'b1) begin
        n_any++; at = i;
        checks++;
        if (rise_o !== 4'b1100) begin
          errors++; $display("FAIL simul_rise got %h exp c", rise_o);
        end
      end
      checks++;
      if ({level_o, rise_o, fall_o, any_rise_o} !== {m_level, m_rise, m_fall, m_any}) begin
        errors++; $display("FAIL simul_model edge %0d got %h exp %h", i,
                           {level_o, rise_o, fall_o, any_rise_o}, {m_level, m_rise, m_fall, m_any});
      end
    end
    checks++;
    if (n_any !== 1 || at !== LAT) begin
      errors++; $display("FAIL simul_any got count %0d edge %0d exp 1 at %0d", n_any, at, LAT);
    end
    raw_i = 4'h0;
    repeat (LAT + 4) step();
  endtask

  task automatic test_boundary();
    logic seen;
    // Held exactly THR synchronised cycles: accepted.
    seen = 1'b0;
    for (int i = 0; i < THR + LAT + 4; i++) begin
      raw_i = (i < THR) ? 4'b0001 : 4'b0000;
      step();
      if (level_o[0] === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b1) begin
      errors++; $display("FAIL boundary_accept got 0 exp 1");
    end
    // Held one cycle short: rejected.
    seen = 1'b0;
    for (int i = 0; i < THR + LAT + 4; i++) begin
      raw_i = (i < THR - 1) ? 4'b0001 : 4'b0000;
      step();
      if (level_o[0] === 1'b1 || rise_o[0] === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL boundary_reject got 1 exp 0");
    end
  endtask

  task automatic test_random();
    int hold [W];
    for (int c = 0; c < W; c++) hold[c] = $urandom_range(1, 12);
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < W; c++) begin
        hold[c]--;
        if (hold[c] == 0) begin
          raw_i[c] = ~raw_i[c];
          hold[c]  = $urandom_range(1, 3 * THR / 2 + 2);
        end
      end
      step();
      checks++;
      if ({level_o, rise_o, fall_o, any_rise_o} !== {m_level, m_rise, m_fall, m_any}) begin
        errors++; $display("FAIL random step %0d got %h exp %h", i,
                           {level_o, rise_o, fall_o, any_rise_o}, {m_level, m_rise, m_fall, m_any});
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_boundary();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
